boreal_feature_extract_mf: RTL and testbench
============================================

Name: boreal_feature_extract_mf

Overview:
Parametrised, multi-feature successor to the fixed 8-channel X/Y spatial feature extractor. It consumes a serial stream of per-channel samples, one channel per valid beat. Each frame is reduced to N_FEAT weighted sums using run-time programmable, double-buffered weights, with per-feature saturation. It also detects frame misalignment. It sits between the channel-serialised front-end and the decoder/cursor mapping stage.

Parameters:
N_CH, 8, channels per frame (>=2)
N_FEAT, 2, number of output features (>=1)
SAMPLE_W, 16, signed sample width
WEIGHT_W, 8, signed weight width
ACC_W, 32, accumulator width; must be >= SAMPLE_W+WEIGHT_W+clog2(N_CH)
OUT_SHIFT, 8, arithmetic right shift applied to the final sum
OUT_W, 16, signed feature output width

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
s_valid  in  1  sample beat valid; no backpressure
s_first  in  1  marks channel-0 sample of a frame; qualified by s_valid
s_data  in  SAMPLE_W  signed sample
w_en  in  1  shadow weight write strobe
w_feat  in  max(1,clog2(N_FEAT))  feature index of write
w_ch  in  clog2(N_CH)  channel index of write
w_data  in  WEIGHT_W  signed weight
w_commit  in  1  request shadow-to-active copy
commit_pending  out  1  commit requested, not yet applied
m_valid  out  1  one-cycle pulse: new features available
m_features  out  N_FEAT*OUT_W  packed features; feature f at [f*OUT_W +: OUT_W]
m_sat  out  N_FEAT  per-feature saturation flag for the current m_features
frame_err  out  1  one-cycle pulse on misaligned s_first
ch_idx  out  clog2(N_CH)  expected channel index of the next beat

Behaviour:
- Reset (async assert, sync deassert handled upstream): ch_idx=0, all accumulators 0, m_features=0, m_sat=0, m_valid=0, frame_err=0, commit_pending=0. Both the shadow and active weight banks clear to 0.
- Accepted beat (s_valid=1): for each f, acc[f] += sext_ACC(s_data * active_w[f][ch_idx]). The product is full-width SAMPLE_W+WEIGHT_W signed. The accumulator wraps at ACC_W; no saturation inside the accumulator.
- Last channel (ch_idx==N_CH-1 on an accepted beat): the sum includes that beat's product. Then sum>>>OUT_SHIFT is clamped to [-2^(OUT_W-1), 2^(OUT_W-1)-1], and m_sat[f]=1 if clamped. m_features, m_sat and a m_valid pulse are registered the next cycle, giving 1-cycle latency from the last beat. Accumulators clear and ch_idx returns to 0. Otherwise ch_idx increments.
- m_features/m_sat hold until the next frame completes.
- s_first=1 with ch_idx==0: normal.
- s_first=1 with ch_idx!=0: frame_err pulses next cycle. The partial frame is discarded and accumulators cleared. The beat is processed as channel 0 (acc = that beat's product), and ch_idx goes to 1 (or completes immediately if N_CH==1, not allowed).
- s_first=0 with ch_idx==0 is accepted as channel 0 (no error; s_first is optional).
- Weight write: w_en writes shadow[w_feat][w_ch] at the clock edge. Out-of-range w_feat is ignored.
- Commit: w_commit sets commit_pending at the next edge. While pending, active<=shadow in the first cycle where either (a) ch_idx==0 and s_valid==0, or (b) a last-channel beat is accepted; the completing frame still uses the old weights. commit_pending clears in that same edge.
- The active bank never changes mid-frame.
- w_en in the same cycle as the copy: the copy takes the pre-write shadow value; the new write stays in shadow for a later commit.
- w_commit while already pending: no additional effect.
- rst_n asserted mid-frame: everything returns to reset values immediately, including both weight banks; the partial frame is lost.

Decomposition:
- Package boreal_fe_pkg: default parameter constants, a saturate-and-shift function (sum, shift, out width), and the index width helper.
- Sub-module boreal_fe_weight_bank: shadow and active arrays, write port, commit_pending logic, copy enable input. It exposes active weights as a packed bus.
- The top level holds the channel counter, accumulators, output registers and frame_err.

Test Plan:
- Basic: program f0 ch0=-127, ch1=127; f1 ch2=-127, ch3=127; commit. Frame ch0=100, ch1=300, others 0 -> m_valid 1 cycle after ch7; f0=99 ((-12700+38100)>>>8), f1=0, m_sat=00.
- Saturation: all f0 weights=127, all samples 32767 -> f0=32767, m_sat[0]=1. All samples -32768 -> f0=-32768, m_sat[0]=1.
- Misalignment: s_first on the 4th beat -> frame_err pulse, no m_valid. The following 7 beats complete a frame computed only from the s_first beat onward.
- Commit timing: commit asserted after the ch3 beat with new f0 weights -> the current frame uses old weights, the next frame uses new ones. commit_pending is high until the ch7 beat edge.
- Write/copy collision: w_en and the copy condition in the same cycle -> the active bank keeps the old value; a second commit applies the new value.
- Reset mid-frame: rst_n low after 5 beats -> outputs 0, ch_idx 0, weights 0. Reprogram and send one full frame -> correct result, no frame_err.

Source files
------------

// File: rtl/boreal_fe_pkg.sv
// -----------------------------------------------------------------------------
// boreal_fe_pkg
// Shared constants and helpers for the multi-feature spatial extractor.
//   DEF_*      : default parameter values for the extractor and its weight bank
//   idx_w()    : index width for an n-entry table (never less than 1 bit)
//   sat_shift(): arithmetic right shift followed by signed clamp to out_w bits
//   sat_hit()  : flag telling whether sat_shift() had to clamp
// -----------------------------------------------------------------------------
package boreal_fe_pkg;

    localparam int DEF_N_CH      = 8;
    localparam int DEF_N_FEAT    = 2;
    localparam int DEF_SAMPLE_W  = 16;
    localparam int DEF_WEIGHT_W  = 8;
    localparam int DEF_ACC_W     = 32;
    localparam int DEF_OUT_SHIFT = 8;
    localparam int DEF_OUT_W     = 16;

    // Working width for the shift/clamp helpers; accumulators are sign
    // extended into it so any ACC_W up to 64 is handled by one function.
    localparam int MAX_W = 64;

    function automatic int idx_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    function automatic logic signed [MAX_W-1:0] sat_shift(
        input logic signed [MAX_W-1:0] sum,
        input int                      shift,
        input int                      out_w
    );
        logic signed [MAX_W-1:0] sh;
        logic signed [MAX_W-1:0] hi;
        logic signed [MAX_W-1:0] lo;
        sh = sum >>> shift;
        hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (out_w - 1));
        if (sh > hi) begin
            return hi;
        end else if (sh < lo) begin
            return lo;
        end
        return sh;
    endfunction

    function automatic logic sat_hit(
        input logic signed [MAX_W-1:0] sum,
        input int                      shift,
        input int                      out_w
    );
        logic signed [MAX_W-1:0] sh;
        logic signed [MAX_W-1:0] hi;
        logic signed [MAX_W-1:0] lo;
        sh = sum >>> shift;
        hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (out_w - 1));
        return (sh > hi) || (sh < lo);
    endfunction

endpackage

// File: rtl/boreal_fe_weight_bank.sv
// -----------------------------------------------------------------------------
// boreal_fe_weight_bank
// Double-buffered weight storage. Writes land in the shadow bank; a commit
// request arms a pending flag and the whole shadow bank is copied to the
// active bank on the first cycle the datapath reports a safe boundary.
// Ports:
//   clk, rst_n   : clock, async active-low reset (clears both banks)
//   i_w_en       : shadow write strobe
//   i_w_feat     : feature index of the write (out-of-range ignored)
//   i_w_ch       : channel index of the write (out-of-range ignored)
//   i_w_data     : signed weight value
//   i_commit     : request a shadow-to-active copy
//   i_copy_ok    : datapath is at a frame boundary this cycle
//   o_pending    : commit requested but not yet applied
//   o_active_w   : active bank, weight [f][c] at [(f*N_CH+c)*WEIGHT_W +: WEIGHT_W]
// -----------------------------------------------------------------------------
module boreal_fe_weight_bank
    import boreal_fe_pkg::*;
#(
    parameter int N_CH     = DEF_N_CH,
    parameter int N_FEAT   = DEF_N_FEAT,
    parameter int WEIGHT_W = DEF_WEIGHT_W
)(
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              i_w_en,
    input  logic [idx_w(N_FEAT)-1:0]          i_w_feat,
    input  logic [idx_w(N_CH)-1:0]            i_w_ch,
    input  logic signed [WEIGHT_W-1:0]        i_w_data,
    input  logic                              i_commit,
    input  logic                              i_copy_ok,
    output logic                              o_pending,
    output logic [N_FEAT*N_CH*WEIGHT_W-1:0]   o_active_w
);

    logic signed [WEIGHT_W-1:0] r_shadow [N_FEAT][N_CH];
    logic signed [WEIGHT_W-1:0] r_active [N_FEAT][N_CH];
    logic                       r_pending;
    logic                       w_copy;
    logic                       w_wr_ok;

    assign w_copy  = r_pending && i_copy_ok;
    assign w_wr_ok = i_w_en && (int'(i_w_feat) < N_FEAT) && (int'(i_w_ch) < N_CH);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int f = 0; f < N_FEAT; f++) begin
                for (int c = 0; c < N_CH; c++) begin
                    r_shadow[f][c] <= '0;
                end
            end
        end else if (w_wr_ok) begin
            r_shadow[i_w_feat][i_w_ch] <= i_w_data;
        end
    end

    // The copy samples r_shadow before this edge's write, so a write that
    // collides with the copy waits in shadow for the next commit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int f = 0; f < N_FEAT; f++) begin
                for (int c = 0; c < N_CH; c++) begin
                    r_active[f][c] <= '0;
                end
            end
        end else if (w_copy) begin
            for (int f = 0; f < N_FEAT; f++) begin
                for (int c = 0; c < N_CH; c++) begin
                    r_active[f][c] <= r_shadow[f][c];
                end
            end
        end
    end

    // A commit arriving while one is already pending (including on the copy
    // edge itself) is absorbed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pending <= 1'b0;
        end else if (w_copy) begin
            r_pending <= 1'b0;
        end else if (i_commit) begin
            r_pending <= 1'b1;
        end
    end

    assign o_pending = r_pending;

    for (genvar f = 0; f < N_FEAT; f++) begin : g_feat
        for (genvar c = 0; c < N_CH; c++) begin : g_ch
            assign o_active_w[(f*N_CH + c)*WEIGHT_W +: WEIGHT_W] = r_active[f][c];
        end
    end

endmodule

// File: rtl/boreal_feature_extract_mf.sv
// -----------------------------------------------------------------------------
// boreal_feature_extract_mf
// Reduces a channel-serial sample stream to N_FEAT weighted sums per frame,
// shifts and clamps each sum to OUT_W bits, and flags misaligned frame starts.
// Ports:
//   clk, rst_n      : clock, async active-low reset
//   s_valid         : sample beat valid (no backpressure)
//   s_first         : channel-0 marker, qualified by s_valid
//   s_data          : signed sample
//   w_en/w_feat/w_ch/w_data : shadow weight write port
//   w_commit        : request shadow-to-active weight copy
//   commit_pending  : commit requested, not yet applied
//   m_valid         : one-cycle pulse when m_features/m_sat update
//   m_features      : feature f at [f*OUT_W +: OUT_W], held between frames
//   m_sat           : per-feature clamp flag for the current m_features
//   frame_err       : one-cycle pulse after an s_first seen mid-frame
//   ch_idx          : channel index expected on the next beat
// -----------------------------------------------------------------------------
module boreal_feature_extract_mf
    import boreal_fe_pkg::*;
#(
    parameter int N_CH      = DEF_N_CH,
    parameter int N_FEAT    = DEF_N_FEAT,
    parameter int SAMPLE_W  = DEF_SAMPLE_W,
    parameter int WEIGHT_W  = DEF_WEIGHT_W,
    parameter int ACC_W     = DEF_ACC_W,
    parameter int OUT_SHIFT = DEF_OUT_SHIFT,
    parameter int OUT_W     = DEF_OUT_W
)(
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          s_valid,
    input  logic                          s_first,
    input  logic signed [SAMPLE_W-1:0]    s_data,
    input  logic                          w_en,
    input  logic [idx_w(N_FEAT)-1:0]      w_feat,
    input  logic [idx_w(N_CH)-1:0]        w_ch,
    input  logic signed [WEIGHT_W-1:0]    w_data,
    input  logic                          w_commit,
    output logic                          commit_pending,
    output logic                          m_valid,
    output logic [N_FEAT*OUT_W-1:0]       m_features,
    output logic [N_FEAT-1:0]             m_sat,
    output logic                          frame_err,
    output logic [idx_w(N_CH)-1:0]        ch_idx
);

    localparam int            CW      = idx_w(N_CH);
    localparam int            PW      = SAMPLE_W + WEIGHT_W;
    localparam logic [CW-1:0] LAST_CH = CW'(N_CH - 1);

    logic [CW-1:0]                      r_ch;
    logic signed [ACC_W-1:0]            r_acc [N_FEAT];
    logic [N_FEAT*OUT_W-1:0]            r_feat;
    logic [N_FEAT-1:0]                  r_sat;
    logic                               r_valid;
    logic                               r_err;

    logic [N_FEAT*N_CH*WEIGHT_W-1:0]    w_active;
    logic                               w_restart;
    logic                               w_last;
    logic                               w_copy_ok;
    logic [CW-1:0]                      w_eff_ch;
    logic signed [WEIGHT_W-1:0]         w_wsel [N_FEAT];
    logic signed [PW-1:0]               w_prod [N_FEAT];
    logic signed [ACC_W-1:0]            w_base [N_FEAT];
    logic signed [ACC_W-1:0]            w_ext  [N_FEAT];
    logic signed [ACC_W-1:0]            w_sum  [N_FEAT];

    // A frame start seen mid-frame drops the partial sum and treats the beat
    // as channel 0; since N_CH >= 2 such a beat can never also be the last.
    assign w_restart = s_valid && s_first && (r_ch != '0);
    assign w_eff_ch  = w_restart ? '0 : r_ch;
    assign w_last    = s_valid && (w_eff_ch == LAST_CH);

    // Safe points for a weight copy: idle at a frame boundary, or the edge
    // that completes a frame (whose sum already used the old bank).
    assign w_copy_ok = ((r_ch == '0) && !s_valid) || w_last;

    boreal_fe_weight_bank #(
        .N_CH     (N_CH),
        .N_FEAT   (N_FEAT),
        .WEIGHT_W (WEIGHT_W)
    ) u_bank (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_w_en     (w_en),
        .i_w_feat   (w_feat),
        .i_w_ch     (w_ch),
        .i_w_data   (w_data),
        .i_commit   (w_commit),
        .i_copy_ok  (w_copy_ok),
        .o_pending  (commit_pending),
        .o_active_w (w_active)
    );

    always_comb begin
        for (int f = 0; f < N_FEAT; f++) begin
            w_wsel[f] = w_active[(f*N_CH + int'(w_eff_ch))*WEIGHT_W +: WEIGHT_W];
            w_prod[f] = PW'(s_data) * PW'(w_wsel[f]);
            w_ext[f]  = ACC_W'(w_prod[f]);
            w_base[f] = w_restart ? '0 : r_acc[f];
            w_sum[f]  = w_base[f] + w_ext[f];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ch    <= '0;
            r_feat  <= '0;
            r_sat   <= '0;
            r_valid <= 1'b0;
            r_err   <= 1'b0;
            for (int f = 0; f < N_FEAT; f++) begin
                r_acc[f] <= '0;
            end
        end else begin
            r_valid <= w_last;
            r_err   <= w_restart;
            if (s_valid) begin
                if (w_last) begin
                    r_ch <= '0;
                    for (int f = 0; f < N_FEAT; f++) begin
                        r_acc[f] <= '0;
                        r_feat[f*OUT_W +: OUT_W] <=
                            OUT_W'(sat_shift(MAX_W'(w_sum[f]), OUT_SHIFT, OUT_W));
                        r_sat[f] <= sat_hit(MAX_W'(w_sum[f]), OUT_SHIFT, OUT_W);
                    end
                end else begin
                    r_ch <= w_eff_ch + CW'(1);
                    for (int f = 0; f < N_FEAT; f++) begin
                        r_acc[f] <= w_sum[f];
                    end
                end
            end
        end
    end

    assign ch_idx     = r_ch;
    assign m_valid    = r_valid;
    assign m_features = r_feat;
    assign m_sat      = r_sat;
    assign frame_err  = r_err;

endmodule

// File: tb/tb_boreal_feature_extract_mf.sv
module tb_boreal_feature_extract_mf;

    localparam int N_CH      = 8;
    localparam int N_FEAT    = 2;
    localparam int OUT_SHIFT = 8;

    logic               clk = 1'b0;
    logic               rst_n = 1'b1;
    logic               s_valid = 1'b0;
    logic               s_first = 1'b0;
    logic signed [15:0] s_data = '0;
    logic               w_en = 1'b0;
    logic [0:0]         w_feat = '0;
    logic [2:0]         w_ch = '0;
    logic signed [7:0]  w_data = '0;
    logic               w_commit = 1'b0;
    logic               commit_pending;
    logic               m_valid;
    logic [31:0]        m_features;
    logic [1:0]         m_sat;
    logic               frame_err;
    logic [2:0]         ch_idx;

    always #5 clk = ~clk;

    boreal_feature_extract_mf dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .s_valid        (s_valid),
        .s_first        (s_first),
        .s_data         (s_data),
        .w_en           (w_en),
        .w_feat         (w_feat),
        .w_ch           (w_ch),
        .w_data         (w_data),
        .w_commit       (w_commit),
        .commit_pending (commit_pending),
        .m_valid        (m_valid),
        .m_features     (m_features),
        .m_sat          (m_sat),
        .frame_err      (frame_err),
        .ch_idx         (ch_idx)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    // ---------------- frame-level reference model ----------------
    int          shadow [N_FEAT][N_CH];
    int          active [N_FEAT][N_CH];
    int          snap   [N_FEAT][N_CH];
    int          frame_q[$];
    bit          pend_e;
    bit          valid_e;
    bit          err_e;
    logic [31:0] feat_e = '0;
    logic [1:0]  sat_e = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            foreach (shadow[f, c]) begin
                shadow[f][c] = 0;
                active[f][c] = 0;
            end
            frame_q.delete();
            pend_e  = 1'b0;
            valid_e = 1'b0;
            err_e   = 1'b0;
            feat_e  = '0;
            sat_e   = '0;
        end else begin
            bit     idle;
            bit     done;
            longint sum;
            longint sh;
            snap  = shadow;
            idle  = (frame_q.size() == 0) && !s_valid;
            done  = 1'b0;
            err_e = 1'b0;
            if (s_valid) begin
                if (s_first && frame_q.size() != 0) begin
                    err_e = 1'b1;
                    frame_q.delete();
                end
                frame_q.push_back(int'(s_data));
                if (frame_q.size() == N_CH) begin
                    done = 1'b1;
                    for (int f = 0; f < N_FEAT; f++) begin
                        sum = 0;
                        for (int c = 0; c < N_CH; c++) begin
                            sum += longint'(frame_q[c]) * longint'(active[f][c]);
                        end
                        sum = longint'(int'(sum));
                        sh  = sum >>> OUT_SHIFT;
                        if (sh > 32767) begin
                            feat_e[f*16 +: 16] = 16'h7fff;
                            sat_e[f] = 1'b1;
                        end else if (sh < -32768) begin
                            feat_e[f*16 +: 16] = 16'h8000;
                            sat_e[f] = 1'b1;
                        end else begin
                            feat_e[f*16 +: 16] = 16'(sh);
                            sat_e[f] = 1'b0;
                        end
                    end
                    frame_q.delete();
                end
            end
            valid_e = done;
            if (pend_e && (idle || done)) begin
                active = snap;
                pend_e = 1'b0;
            end else if (w_commit) begin
                pend_e = 1'b1;
            end
            if (w_en) shadow[w_feat][w_ch] = int'(w_data);
        end
    end

    always @(negedge clk) begin
        chk("m_valid",        32'(m_valid),        32'(valid_e));
        chk("frame_err",      32'(frame_err),      32'(err_e));
        chk("commit_pending", 32'(commit_pending), 32'(pend_e));
        chk("ch_idx",         32'(ch_idx),         32'(frame_q.size()));
        chk("m_features",     m_features,          feat_e);
        chk("m_sat",          32'(m_sat),          32'(sat_e));
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input int d, input bit f);
        s_valid = 1'b1;
        s_first = f;
        s_data  = 16'(d);
        tick();
        s_valid = 1'b0;
        s_first = 1'b0;
        s_data  = '0;
    endtask

    task automatic send_frame(input int d[N_CH]);
        for (int c = 0; c < N_CH; c++) beat(d[c], c == 0);
    endtask

    task automatic wr(input int f, input int c, input int v);
        w_en   = 1'b1;
        w_feat = 1'(f);
        w_ch   = 3'(c);
        w_data = 8'(v);
        tick();
        w_en = 1'b0;
    endtask

    task automatic commit();
        w_commit = 1'b1;
        tick();
        w_commit = 1'b0;
        tick();
    endtask

    task automatic expect_frame(input string name, input int f0, input int f1, input logic [1:0] sat);
        int n = 0;
        while (!m_valid && n < 4) begin
            tick();
            n++;
        end
        chk({name, "_valid"}, 32'(m_valid), 32'd1);
        chk({name, "_f0"}, 32'($signed(m_features[15:0])), 32'(f0));
        chk({name, "_f1"}, 32'($signed(m_features[31:16])), 32'(f1));
        chk({name, "_sat"}, 32'(m_sat), 32'(sat));
    endtask

    initial begin
        #1 rst_n = 1'b0;
        repeat (3) tick();
        chk("rst_features", m_features, 32'd0);
        chk("rst_ch_idx", 32'(ch_idx), 32'd0);
        chk("rst_valid", 32'(m_valid), 32'd0);
        rst_n = 1'b1;
        tick();

        // basic
        wr(0, 0, -127); wr(0, 1, 127); wr(1, 2, -127); wr(1, 3, 127);
        commit();
        send_frame('{100, 300, 0, 0, 0, 0, 0, 0});
        expect_frame("basic", 99, 0, 2'b00);
        tick();
        chk("basic_pulse", 32'(m_valid), 32'd0);
        chk("basic_hold", 32'($signed(m_features[15:0])), 32'd99);

        // misalignment on the 4th beat
        beat(5, 1); beat(6, 0); beat(7, 0);
        beat(100, 1);
        chk("mis_err", 32'(frame_err), 32'd1);
        chk("mis_novalid", 32'(m_valid), 32'd0);
        chk("mis_ch", 32'(ch_idx), 32'd1);
        beat(300, 0);
        for (int c = 2; c < N_CH; c++) beat(0, 0);
        expect_frame("mis", 99, 0, 2'b00);

        // commit mid-frame
        wr(0, 0, 64); wr(0, 1, 64);
        beat(100, 1); beat(300, 0); beat(0, 0); beat(0, 0);
        w_commit = 1'b1;
        beat(0, 0);
        w_commit = 1'b0;
        beat(0, 0);
        chk("cmt_pending", 32'(commit_pending), 32'd1);
        beat(0, 0); beat(0, 0);
        chk("cmt_cleared", 32'(commit_pending), 32'd0);
        expect_frame("cmt_old", 99, 0, 2'b00);
        send_frame('{100, 300, 0, 0, 0, 0, 0, 0});
        expect_frame("cmt_new", 100, 0, 2'b00);

        // saturation
        for (int c = 0; c < N_CH; c++) wr(0, c, 127);
        commit();
        send_frame('{32767, 32767, 32767, 32767, 32767, 32767, 32767, 32767});
        expect_frame("sat_pos", 32767, 0, 2'b01);
        send_frame('{-32768, -32768, -32768, -32768, -32768, -32768, -32768, -32768});
        expect_frame("sat_neg", -32768, 0, 2'b01);

        // write colliding with the copy edge
        w_commit = 1'b1;
        tick();
        w_commit = 1'b0;
        wr(1, 0, 100);
        chk("col_pending", 32'(commit_pending), 32'd0);
        send_frame('{256, 0, 0, 0, 0, 0, 0, 0});
        expect_frame("col_old", 127, 0, 2'b00);
        commit();
        send_frame('{256, 0, 0, 0, 0, 0, 0, 0});
        expect_frame("col_new", 127, 100, 2'b00);

        // reset mid-frame
        beat(1000, 1); beat(1000, 0); beat(1000, 0); beat(1000, 0); beat(1000, 0);
        rst_n = 1'b0;
        #1;
        chk("rmid_features", m_features, 32'd0);
        chk("rmid_sat", 32'(m_sat), 32'd0);
        chk("rmid_ch", 32'(ch_idx), 32'd0);
        tick(); tick();
        rst_n = 1'b1;
        tick();
        send_frame('{1000, 1000, 1000, 1000, 1000, 1000, 1000, 1000});
        expect_frame("rmid_zero_w", 0, 0, 2'b00);
        wr(0, 0, -127); wr(0, 1, 127);
        commit();
        send_frame('{100, 300, 0, 0, 0, 0, 0, 0});
        expect_frame("rmid_reprog", 99, 0, 2'b00);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            s_valid  = ($urandom_range(3) != 0);
            s_first  = ($urandom_range(15) == 0);
            s_data   = 16'($urandom);
            w_en     = ($urandom_range(7) == 0);
            w_feat   = 1'($urandom);
            w_ch     = 3'($urandom);
            w_data   = 8'($urandom);
            w_commit = ($urandom_range(31) == 0);
            tick();
        end
        s_valid = 1'b0; s_first = 1'b0; w_en = 1'b0; w_commit = 1'b0;
        repeat (4) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
